fm_spy_buffer_mc: RTL and testbench

Multi-channel spy buffer for the fast-monitoring path, succeeding the fixed per-slice freeze/playback scheme. It captures N_CH channels of monitor data into a shared-pointer circular memory with configurable depth and pre/post-trigger windowing. After capture it freezes for register-side readout, or replays the frozen contents in single-pass or loop mode over a valid/ready stream. It sits between the per-slice monitor taps and the control-register readout in fm_data.

---
 rtl/fm_spy_pkg.sv | 24 ++
 rtl/fm_spy_ram.sv | 23 ++
 rtl/fm_spy_buffer_mc.sv | 212 +++++++++++++++++++++
 tb/tb_fm_spy_buffer_mc.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_spy_pkg.sv
// Shared types for the multi-channel fast-monitor spy buffer.
// Capture/playback FSM states, playback modes and the stored word layout.
package fm_spy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_POST     = 3'd2,
    ST_FROZEN   = 3'd3,
    ST_PLAYBACK = 3'd4
  } spy_state_e;

  localparam int PB_OFF  = 0;
  localparam int PB_ONCE = 1;
  localparam int PB_LOOP = 2;

  localparam int SPY_DATA_W = 64;

  typedef struct packed {
    logic                  valid;
    logic [SPY_DATA_W-1:0] data;
  } spy_word_t;

endpackage

// File: rtl/fm_spy_ram.sv
// Simple dual-port memory holding all spy channels side by side.
// One write port, one read port with a registered read output.
module fm_spy_ram #(
  parameter int W  = 18,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/fm_spy_buffer_mc.sv
// Multi-channel spy buffer: windowed capture, frozen register readout,
// and single-pass or looping playback through a 2-entry skid buffer.
module fm_spy_buffer_mc
  import fm_spy_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int PB_MODE_W  = 2
) (
  input  logic                         clk_hs,
  input  logic                         rst_hs_n,
  input  logic [N_CH*DATA_W-1:0]       ch_data,
  input  logic [N_CH-1:0]              ch_valid,
  input  logic                         arm,
  input  logic                         trigger,
  input  logic                         freeze_req,
  input  logic [DEPTH_LOG2-1:0]        post_trig_len,
  input  logic [PB_MODE_W-1:0]         playback_mode,
  input  logic                         pb_start,
  input  logic                         rd_en,
  input  logic [$clog2(N_CH)-1:0]      rd_ch,
  input  logic [DEPTH_LOG2-1:0]        rd_addr,
  output logic [DATA_W:0]              rd_data,
  output logic                         rd_valid,
  output logic [N_CH*(DATA_W+1)-1:0]   pb_data,
  output logic                         pb_valid,
  input  logic                         pb_ready,
  output logic                         pb_done,
  output logic [2:0]                   state,
  output logic [DEPTH_LOG2:0]          fill,
  output logic [DEPTH_LOG2-1:0]        trig_addr
);

  localparam int DL    = DEPTH_LOG2;
  localparam int WW    = DATA_W + 1;
  localparam int RW    = N_CH * WW;
  localparam int CH_W  = $clog2(N_CH);
  localparam int DEPTH = 1 << DL;
  localparam logic [DL:0] FULL = (DL+1)'(DEPTH);

  spy_state_e    st;
  logic [DL-1:0] wr_ptr;
  logic [DL-1:0] post_cnt;
  logic [DL-1:0] laddr;
  logic          iss_on;
  logic          once_q;
  logic          pend;
  logic [RW-1:0] spare;
  logic          spare_v;
  logic          rd_p1;
  logic          rd_in_q;
  logic [CH_W-1:0] rd_ch_q;

  logic [RW-1:0] wr_word;
  logic [RW-1:0] ram_q;
  logic [WW-1:0] rd_sel;
  logic [DL-1:0] oldest;
  logic [DL-1:0] ram_ra;
  logic          wr_en;
  logic          mode_run;
  logic          mode_once;
  logic          pop;
  logic          room;
  logic          issue;
  logic          stop;
  logic          last;
  logic          reg_rd;
  logic          drained;

  assign state     = st;
  assign oldest    = (fill == FULL) ? wr_ptr : '0;
  assign wr_en     = (st == ST_ARMED) || (st == ST_POST);
  assign mode_once = playback_mode == PB_MODE_W'(PB_ONCE);
  assign mode_run  = mode_once || (playback_mode == PB_MODE_W'(PB_LOOP));
  assign pop       = pb_valid && pb_ready;
  // Issue only if the word can land in a free slot next cycle.
  assign room      = ({2'b0, pb_valid} + {2'b0, spare_v} + {2'b0, pend})
                     <= (3'd1 + {2'b0, pop});
  assign issue     = (st == ST_PLAYBACK) && iss_on && room && mode_run;
  assign stop      = (st == ST_PLAYBACK) && iss_on && room && !mode_run;
  assign last      = {1'b0, laddr} == (fill - 1'b1);
  assign reg_rd    = (st == ST_FROZEN) && rd_en;
  assign ram_ra    = oldest + ((st == ST_PLAYBACK) ? laddr : rd_addr);
  assign drained   = !iss_on && !pend &&
                     (!pb_valid || (pop && !spare_v));

  always_comb begin
    wr_word = '0;
    for (int c = 0; c < N_CH; c++)
      wr_word[c*WW +: WW] = {ch_valid[c], ch_data[c*DATA_W +: DATA_W]};
  end

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < N_CH; c++)
      if (rd_ch_q == c[CH_W-1:0]) rd_sel = ram_q[c*WW +: WW];
  end

  fm_spy_ram #(.W(RW), .AW(DL)) u_ram (
    .clk (clk_hs),
    .we  (wr_en),
    .wa  (wr_ptr),
    .wd  (wr_word),
    .re  (issue || reg_rd),
    .ra  (ram_ra),
    .rd  (ram_q)
  );

  always_ff @(posedge clk_hs) begin
    if (!rst_hs_n) begin
      st        <= ST_IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      trig_addr <= '0;
      post_cnt  <= '0;
      laddr     <= '0;
      iss_on    <= 1'b0;
      once_q    <= 1'b0;
      pend      <= 1'b0;
      spare     <= '0;
      spare_v   <= 1'b0;
      pb_data   <= '0;
      pb_valid  <= 1'b0;
      pb_done   <= 1'b0;
      rd_p1     <= 1'b0;
      rd_in_q   <= 1'b0;
      rd_ch_q   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      pb_done  <= 1'b0;
      pend     <= issue;
      rd_p1    <= reg_rd;
      rd_ch_q  <= rd_ch;
      rd_in_q  <= {1'b0, rd_addr} < fill;
      rd_valid <= rd_p1;
      rd_data  <= (rd_p1 && rd_in_q) ? rd_sel : '0;

      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FULL) fill <= fill + 1'b1;
      end

      if (pb_valid && !pop) begin
        if (pend) begin
          spare   <= ram_q;
          spare_v <= 1'b1;
        end
      end else if (spare_v) begin
        pb_data  <= spare;
        pb_valid <= 1'b1;
        spare_v  <= pend;
        if (pend) spare <= ram_q;
      end else begin
        pb_valid <= pend;
        if (pend) pb_data <= ram_q;
      end

      case (st)
        ST_IDLE: begin
          if (arm) begin
            st     <= ST_ARMED;
            wr_ptr <= '0;
            fill   <= '0;
          end
        end
        ST_ARMED: begin
          if (freeze_req) begin
            st <= ST_FROZEN;
          end else if (trigger) begin
            trig_addr <= wr_ptr;
            post_cnt  <= post_trig_len;
            st <= (post_trig_len == '0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          post_cnt <= post_cnt - 1'b1;
          if (freeze_req || post_cnt == DL'(1)) st <= ST_FROZEN;
        end
        ST_FROZEN: begin
          if (arm) begin
            st     <= ST_ARMED;
            wr_ptr <= '0;
            fill   <= '0;
          end else if (pb_start && mode_run && fill != '0) begin
            st     <= ST_PLAYBACK;
            laddr  <= '0;
            iss_on <= 1'b1;
            once_q <= 1'b0;
          end
        end
        ST_PLAYBACK: begin
          if (issue) begin
            laddr <= last ? '0 : laddr + 1'b1;
            if (last && mode_once) begin
              iss_on <= 1'b0;
              once_q <= 1'b1;
            end
          end
          if (stop) iss_on <= 1'b0;
          if (drained) begin
            st      <= ST_FROZEN;
            pb_done <= once_q;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_spy_buffer_mc.sv
// Self-checking bench for fm_spy_buffer_mc (2 channels, 8-bit, depth 16).
// Scoreboard queues hold expected register-read and playback words.
module tb_fm_spy_buffer_mc;

  logic        clk = 1'b0;
  logic        rst_hs_n = 1'b0;
  logic [15:0] ch_data = '0;
  logic [1:0]  ch_valid = '0;
  logic        arm = 1'b0;
  logic        trigger = 1'b0;
  logic        freeze_req = 1'b0;
  logic [3:0]  post_trig_len = '0;
  logic [1:0]  playback_mode = '0;
  logic        pb_start = 1'b0;
  logic        rd_en = 1'b0;
  logic [0:0]  rd_ch = '0;
  logic [3:0]  rd_addr = '0;
  logic [8:0]  rd_data;
  logic        rd_valid;
  logic [17:0] pb_data;
  logic        pb_valid;
  logic        pb_ready = 1'b0;
  logic        pb_done;
  logic [2:0]  state;
  logic [4:0]  fill;
  logic [3:0]  trig_addr;

  int checks = 0;
  int failures = 0;

  logic [8:0]  rd_exp_q[$];
  int          rq_ch[$];
  int          rq_addr[$];
  logic [17:0] pb_exp_q[$];

  fm_spy_buffer_mc #(
    .N_CH(2), .DATA_W(8), .DEPTH_LOG2(4), .PB_MODE_W(2)
  ) dut (
    .clk_hs(clk), .rst_hs_n(rst_hs_n),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .arm(arm), .trigger(trigger), .freeze_req(freeze_req),
    .post_trig_len(post_trig_len), .playback_mode(playback_mode),
    .pb_start(pb_start), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .pb_data(pb_data), .pb_valid(pb_valid), .pb_ready(pb_ready),
    .pb_done(pb_done), .state(state), .fill(fill),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stored word for sample value v: ch1 = {v[0], v^5A}, ch0 = {1, v}.
  function automatic logic [17:0] wexp(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b[0], b ^ 8'h5A, 1'b1, b};
  endfunction

  function automatic logic [8:0] cexp(input int c, input int v);
    logic [17:0] w;
    w = wexp(v);
    return (c != 0) ? w[17:9] : w[8:0];
  endfunction

  task automatic queue_read(input int c, input int a, input logic [8:0] e);
    rq_ch.push_back(c);
    rq_addr.push_back(a);
    rd_exp_q.push_back(e);
  endtask

  task automatic capture(input int n, input int base, input int trig_i,
                         input int frz_i, input logic [3:0] plen,
                         input int frozen_i, input logic [2:0] pre_st);
    post_trig_len = plen;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < n; i++) begin
      int v;
      logic [7:0] b;
      v = base + i;
      b = v[7:0];
      ch_data    = {b ^ 8'h5A, b};
      ch_valid   = {b[0], 1'b1};
      trigger    = (i == trig_i);
      freeze_req = (i == frz_i);
      @(negedge clk);
      if (i == frozen_i - 1) begin
        checks++;
        if (state !== pre_st) begin
          failures++;
          $display("FAIL capture_pre_state i=%0d got=%0d want=%0d",
                   i, state, pre_st);
        end
      end
      if (i == frozen_i) begin
        checks++;
        if (state !== 3'd3) begin
          failures++;
          $display("FAIL capture_frozen i=%0d got=%0d want=3", i, state);
        end
      end
    end
    trigger = 1'b0;
    freeze_req = 1'b0;
  endtask

  task automatic test_reads;
    int n;
    n = rq_ch.size();
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        int tc;
        int ta;
        tc = rq_ch[k];
        ta = rq_addr[k];
        rd_en   = 1'b1;
        rd_ch   = tc[0:0];
        rd_addr = ta[3:0];
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== (k >= 1 && k <= n)) begin
        failures++;
        $display("FAIL rd_latency k=%0d got=%b want=%b",
                 k, rd_valid, (k >= 1 && k <= n));
      end
      if (rd_valid === 1'b1 && rd_exp_q.size() > 0) begin
        logic [8:0] e;
        e = rd_exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data k=%0d got=%h want=%h", k, rd_data, e);
        end
      end
    end
    rq_ch.delete();
    rq_addr.delete();
    rd_exp_q.delete();
  endtask

  task automatic test_reset;
    bit seen;
    rst_hs_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || fill !== 5'd0 || trig_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset_regs got st=%0d fill=%0d trig=%0d want 0/0/0",
               state, fill, trig_addr);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 9'd0 || pb_valid !== 1'b0 ||
        pb_data !== 18'd0 || pb_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs got rv=%b rd=%h pv=%b pd=%h done=%b want 0",
               rd_valid, rd_data, pb_valid, pb_data, pb_done);
    end
    rst_hs_n = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rd_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL idle_read got rd_valid=1 want 0");
    end
  endtask

  task automatic test_freeze_priority;
    capture(5, 50, 4, 4, 4'd2, 4, 3'd1);
    checks++;
    if (fill !== 5'd5 || trig_addr !== 4'd0) begin
      failures++;
      $display("FAIL freeze_prio got fill=%0d trig=%0d want 5/0",
               fill, trig_addr);
    end
    queue_read(0, 7, 9'd0);
    queue_read(1, 0, cexp(1, 50));
    queue_read(0, 4, cexp(0, 54));
    queue_read(1, 5, 9'd0);
    test_reads();
  endtask

  task automatic test_capture_trigger;
    capture(40, 0, 30, -1, 4'd3, 33, 3'd2);
    checks++;
    if (fill !== 5'd16 || trig_addr !== 4'd14) begin
      failures++;
      $display("FAIL capture_trig got fill=%0d trig=%0d want 16/14",
               fill, trig_addr);
    end
    queue_read(0, 0, cexp(0, 18));
    queue_read(1, 15, cexp(1, 33));
    queue_read(1, 5, cexp(1, 23));
    queue_read(0, 15, cexp(0, 33));
    test_reads();
  endtask

  task automatic test_playback_once;
    int acc;
    bit held;
    logic [17:0] held_data;
    for (int i = 0; i < 16; i++) pb_exp_q.push_back(wexp(18 + i));
    playback_mode = 2'd1;
    pb_ready = 1'b0;
    pb_start = 1'b1;
    @(negedge clk);
    pb_start = 1'b0;
    acc = 0;
    held = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 300 && acc < 16; cyc++) begin
      if (held) begin
        checks++;
        if (pb_valid !== 1'b1 || pb_data !== held_data) begin
          failures++;
          $display("FAIL pb_hold got v=%b d=%h want v=1 d=%h",
                   pb_valid, pb_data, held_data);
        end
      end
      if (pb_done === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL pb_done_early got=1 want=0 acc=%0d", acc);
      end
      pb_ready = 1'($urandom_range(0, 1));
      if (pb_valid === 1'b1 && pb_ready) begin
        logic [17:0] e;
        e = pb_exp_q.pop_front();
        checks++;
        if (pb_data !== e) begin
          failures++;
          $display("FAIL pb_once_word n=%0d got=%h want=%h", acc, pb_data, e);
        end
        acc++;
      end
      held = (pb_valid === 1'b1) && !pb_ready;
      held_data = pb_data;
      @(negedge clk);
    end
    pb_ready = 1'b0;
    checks++;
    if (acc != 16 || state !== 3'd3 || pb_done !== 1'b1) begin
      failures++;
      $display("FAIL pb_once_end got acc=%0d st=%0d done=%b want 16/3/1",
               acc, state, pb_done);
    end
    @(negedge clk);
    checks++;
    if (pb_done !== 1'b0 || pb_valid !== 1'b0) begin
      failures++;
      $display("FAIL pb_once_pulse got done=%b v=%b want 0/0",
               pb_done, pb_valid);
    end
    pb_exp_q.delete();
  endtask

  task automatic test_playback_loop;
    int n;
    int extra;
    bit started;
    bit seen_done;
    playback_mode = 2'd2;
    pb_ready = 1'b1;
    pb_start = 1'b1;
    @(negedge clk);
    pb_start = 1'b0;
    n = 0;
    extra = 0;
    started = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (n >= 20 && state === 3'd3) break;
      if (pb_done === 1'b1) seen_done = 1'b1;
      if (pb_valid === 1'b1) begin
        logic [17:0] e;
        e = wexp(18 + (n % 16));
        checks++;
        if (pb_data !== e) begin
          failures++;
          $display("FAIL pb_loop_word n=%0d got=%h want=%h", n, pb_data, e);
        end
        n++;
        started = 1'b1;
        if (n > 20) extra++;
        if (n == 20) playback_mode = 2'd0;
      end else if (started && playback_mode != 2'd0) begin
        checks++;
        failures++;
        $display("FAIL pb_throughput got bubble at n=%0d want 1/cycle", n);
      end
      @(negedge clk);
    end
    if (pb_done === 1'b1) seen_done = 1'b1;
    checks++;
    if (state !== 3'd3 || n < 20 || extra > 3 || seen_done) begin
      failures++;
      $display("FAIL pb_loop_end got st=%0d n=%0d extra=%0d done=%b",
               state, n, extra, seen_done);
    end
    @(negedge clk);
    checks++;
    if (pb_done !== 1'b0 || pb_valid !== 1'b0) begin
      failures++;
      $display("FAIL pb_loop_quiet got done=%b v=%b want 0/0",
               pb_done, pb_valid);
    end
    pb_ready = 1'b0;
  endtask

  task automatic test_reset_mid_playback;
    playback_mode = 2'd2;
    pb_ready = 1'b1;
    pb_start = 1'b1;
    @(negedge clk);
    pb_start = 1'b0;
    repeat (6) @(negedge clk);
    rst_hs_n = 1'b0;
    @(negedge clk);
    rst_hs_n = 1'b1;
    checks++;
    if (state !== 3'd0 || pb_valid !== 1'b0 || fill !== 5'd0 ||
        pb_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_pb got st=%0d v=%b fill=%0d done=%b",
               state, pb_valid, fill, pb_done);
    end
    playback_mode = 2'd0;
    pb_ready = 1'b0;
    capture(10, 100, -1, 9, 4'd0, 9, 3'd1);
    checks++;
    if (fill !== 5'd10) begin
      failures++;
      $display("FAIL rearm_fill got=%0d want=10", fill);
    end
    queue_read(0, 0, cexp(0, 100));
    queue_read(1, 9, cexp(1, 109));
    test_reads();
  endtask

  task automatic test_post_zero;
    capture(8, 200, 6, -1, 4'd0, 6, 3'd1);
    checks++;
    if (fill !== 5'd7 || trig_addr !== 4'd6) begin
      failures++;
      $display("FAIL post_zero got fill=%0d trig=%0d want 7/6",
               fill, trig_addr);
    end
    queue_read(0, 6, cexp(0, 206));
    queue_read(1, 6, cexp(1, 206));
    queue_read(0, 0, cexp(0, 200));
    queue_read(0, 7, 9'd0);
    test_reads();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_freeze_priority();
    test_capture_trigger();
    test_playback_once();
    test_playback_loop();
    test_reset_mid_playback();
    test_post_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
